// File: rtl/pulse_spacer_if.sv
// Request/replay bundle for pulse_spacer: session level and request strobe in,
// start/a pulses plus pending status out.
interface pulse_spacer_if #(
  parameter int DEPTH = 4
) ();
  logic                         start_in;
  logic                         req_in;
  logic                         start;
  logic                         a;
  logic [$clog2(DEPTH+1)-1:0]   pend;
  logic                         busy;
  logic                         overflow;

  modport master (
    output start_in, req_in,
    input  start, a, pend, busy, overflow
  );

  modport slave (
    input  start_in, req_in,
    output start, a, pend, busy, overflow
  );
endinterface

// File: rtl/pulse_spacer.sv
// Session-start pulser and spaced request replayer. Build with PULSE_SPACER_ASSERT_EN
// defined to embed protocol assertions; logic is identical either way.
module pulse_spacer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pulse_spacer_if.slave bus
);
  localparam int PW = $clog2(DEPTH+1);
  localparam int GW = $clog2(GAP+1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_e;

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic            a_q, a_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            sin_q, sin_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            req_acc, issue;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    a_d     = 1'b0;
    gcnt_d  = gcnt_q;
    ovf_d   = ovf_q;
    sin_d   = bus.start_in;
    issue   = 1'b0;
    req_acc = (state_q != S_IDLE) && bus.req_in;
    case (state_q)
      S_IDLE: begin
        if (bus.start_in && !sin_q) begin
          start_d = 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (pend_q != '0) begin
          issue   = 1'b1;
          a_d     = 1'b1;
          gcnt_d  = GW'(GAP);
          state_d = S_GAP;
        end else if (!bus.start_in && !bus.req_in) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q - GW'(1);
        if (gcnt_q == GW'(1)) state_d = S_ACTIVE;
      end
      default: state_d = S_IDLE;
    endcase

    // issue decision uses the pre-edge count, so req+issue nets to zero
    pend_d = pend_q;
    if (req_acc && !issue) begin
      if (pend_q == PW'(DEPTH)) ovf_d = 1'b1;
      else                      pend_d = pend_q + PW'(1);
    end else if (!req_acc && issue) begin
      pend_d = pend_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      a_q     <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      sin_q   <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      sin_q   <= sin_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.start    = start_q;
  assign bus.a        = a_q;
  assign bus.pend     = pend_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.overflow = ovf_q;

`ifdef PULSE_SPACER_ASSERT_EN
  ap_start_gap: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(bus.start) |=> not (bus.a [*2]))
    $info("ap_start_gap pass %0t", $time); else $error("ap_start_gap fail %0t", $time);
  ap_a_single: assert property (@(posedge clk) disable iff (!rst_n) bus.a |=> !bus.a)
    $info("ap_a_single pass %0t", $time); else $error("ap_a_single fail %0t", $time);
  ap_start_single: assert property (@(posedge clk) disable iff (!rst_n) bus.start |=> !bus.start)
    $info("ap_start_single pass %0t", $time); else $error("ap_start_single fail %0t", $time);
  ap_pend_max: assert property (@(posedge clk) disable iff (!rst_n) pend_q <= PW'(DEPTH))
    $info("ap_pend_max pass %0t", $time); else $error("ap_pend_max fail %0t", $time);
  ap_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n) !bus.busy |-> !bus.a)
    $info("ap_idle_quiet pass %0t", $time); else $error("ap_idle_quiet fail %0t", $time);
`else
  // no embedded checks in this build
`endif
endmodule

// File: tb/tb_pulse_spacer.sv
// Scoreboard bench for pulse_spacer: directed stimulus pushes expected start/a
// events (with cycle stamps); a negedge monitor pops and compares them.
module tb_pulse_spacer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_spacer_if #(.DEPTH(4)) b1 ();
  pulse_spacer_if #(.DEPTH(4)) b2 ();

  pulse_spacer #(.DEPTH(4), .GAP(1)) u_g1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pulse_spacer #(.DEPTH(4), .GAP(3)) u_g3 (.clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct { bit k; int c; } ev_t;  // k: 0=start, 1=a
  ev_t q0[$];
  ev_t q1[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  prev_a [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic push(input int d, input bit k, input int c);
    ev_t e;
    e.k = k; e.c = c;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic match(input int d, input bit k);
    ev_t e;
    bit  ok;
    ok = 1'b0;
    e.k = 1'b0; e.c = -1;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    total++;
    if (!ok || e.k != k || e.c != cyc) begin
      bad++;
      $display("FAIL ev_dut%0d_%s: seen at cyc %0d, want kind %0d at cyc %0d (queued=%0d)",
               d, k ? "a" : "start", cyc, e.k, e.c, ok);
    end
  endtask

  task automatic mon(input int d, input logic s, input logic a);
    if (s === 1'b1) match(d, 1'b0);
    if (a === 1'b1) begin
      match(d, 1'b1);
      total++;
      if (prev_a[d]) begin
        bad++;
        $display("FAIL a_back_to_back_dut%0d: a high at cyc %0d and %0d", d, cyc - 1, cyc);
      end
    end
    prev_a[d] = (a === 1'b1);
  endtask

  always @(negedge clk) if (rst_n) begin
    mon(0, b1.start, b1.a);
    mon(1, b2.start, b2.a);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s;

  initial begin
    b1.start_in = 0; b1.req_in = 0;
    b2.start_in = 0; b2.req_in = 0;
    tick(2);
    chk("rst_start", b1.start, 0);
    chk("rst_a", b1.a, 0);
    chk("rst_pend", b1.pend, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_ovf", b1.overflow, 0);

    // start_in held high through reset still produces a start pulse
    b1.start_in = 1; tick(1);
    rst_n = 1; push(0, 0, cyc + 1); tick(1);
    chk("hold_busy", b1.busy, 1);
    b1.start_in = 0; tick(2);
    chk("hold_close_busy", b1.busy, 0);

    // single session, one request
    b1.start_in = 1; push(0, 0, cyc + 1); tick(1);
    chk("t1_busy", b1.busy, 1);
    push(0, 1, cyc + 2);
    b1.req_in = 1; tick(1); b1.req_in = 0;
    chk("t1_pend", b1.pend, 1);
    tick(1);
    chk("t1_a", b1.a, 1);
    b1.start_in = 0; tick(3);
    chk("t1_busy_end", b1.busy, 0);

    // three back-to-back requests: a = 1,0,1,0,1
    b1.start_in = 1; push(0, 0, cyc + 1); tick(1);
    s = cyc;
    push(0, 1, s + 2); push(0, 1, s + 4); push(0, 1, s + 6);
    b1.req_in = 1; tick(3);
    chk("t2_pend_peak", b1.pend, 2);
    b1.req_in = 0; tick(3);
    chk("t2_pend_drain", b1.pend, 0);
    b1.start_in = 0; tick(3);
    chk("t2_busy_end", b1.busy, 0);

    // restart while busy: no second start, drain before IDLE
    b1.start_in = 1; push(0, 0, cyc + 1); tick(1);
    s = cyc;
    push(0, 1, s + 2); push(0, 1, s + 4); push(0, 1, s + 6);
    b1.req_in = 1; tick(2);
    b1.start_in = 0; tick(1);
    chk("t4_pend", b1.pend, 2);
    b1.req_in = 0; b1.start_in = 1; tick(1);
    b1.start_in = 0; tick(3);
    chk("t4_busy_draining", b1.busy, 1);
    tick(1);
    chk("t4_busy_end", b1.busy, 0);

    // overflow on GAP=3 instance: one lone request, then six in a row
    b2.start_in = 1; push(1, 0, cyc + 1); tick(1);
    s = cyc;
    for (int i = 0; i < 6; i++) push(1, 1, s + 2 + 4 * i);
    b2.req_in = 1; tick(1);
    b2.req_in = 0; tick(1);
    b2.req_in = 1; tick(5);
    chk("t3_pend_full", b2.pend, 4);
    chk("t3_ovf_not_yet", b2.overflow, 0);
    tick(1); b2.req_in = 0;
    chk("t3_pend_sat", b2.pend, 4);
    chk("t3_ovf_set", b2.overflow, 1);
    b2.start_in = 0; tick(18);
    chk("t3_busy_end", b2.busy, 0);
    chk("t3_pend_end", b2.pend, 0);
    chk("t3_ovf_sticky", b2.overflow, 1);

    // reset in GAP with three pending
    b2.start_in = 1; push(1, 0, cyc + 1); tick(1);
    s = cyc;
    push(1, 1, s + 2);
    b2.req_in = 1; tick(4); b2.req_in = 0;
    chk("t5_pend_pre", b2.pend, 3);
    chk("t5_busy_pre", b2.busy, 1);
    rst_n = 0; b2.start_in = 0; tick(1);
    chk("t5_start", b2.start, 0);
    chk("t5_a", b2.a, 0);
    chk("t5_pend", b2.pend, 0);
    chk("t5_busy", b2.busy, 0);
    chk("t5_ovf", b2.overflow, 0);
    rst_n = 1; tick(2);

    // requests with no session open are dropped
    b1.req_in = 1; tick(3);
    chk("t6_pend", b1.pend, 0);
    chk("t6_a", b1.a, 0);
    chk("t6_busy", b1.busy, 0);
    b1.req_in = 0; tick(2);

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_spacer.md
# pulse_spacer

Upstream stimulus stage for the start/`a` protocol checker. It detects a rising edge on a session-enable level and emits a one-cycle `start` pulse. During the session it buffers incoming requests in a saturating pending counter. It replays them on `a` with a guaranteed idle gap between pulses, so `a` is never high on two consecutive cycles. The downstream "`$rose(start) |=> not a[*2]`" check therefore always passes on legal traffic.

## Interface
- `DEPTH`, default 4: maximum pending requests; legal values are 1 or greater.
- `GAP`, default 1: minimum number of idle cycles between `a` pulses; legal values are 1 or greater. `GAP`=0 is illegal.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start_in`  in  1: session-enable level.
- `req_in`  in  1: request strobe, sampled every edge.
- `start`  out  1: one-cycle session-start pulse, registered.
- `a`  out  1: replayed request pulse, registered.
- `pend`  out  `$clog2(DEPTH+1)`: current pending count.
- `busy`  out  1: high whenever the state is not IDLE.
- `overflow`  out  1: sticky; set when a request arrives while `pend`==`DEPTH`.

## Operation
- Internal registers:
  - `start_in_d` holds the previous sample of `start_in`.
  - `gcnt` is the gap counter, `$clog2(GAP+1)` bits wide.
- States and transitions:
  - IDLE: if `start_in`=1 and `start_in_d`=0, set `start`<=1 and go to ACTIVE. Otherwise `start`<=0. `req_in` is ignored in IDLE.
  - ACTIVE: if `pend`>0, set `a`<=1, decrement `pend`, load `gcnt`<=`GAP`, and go to GAP. If instead `start_in`=0, `pend`=0 and `req_in`=0, go to IDLE. Otherwise stay in ACTIVE.
  - GAP: set `a`<=0 and decrement `gcnt`. When `gcnt` reaches 1, return to ACTIVE. Requests are still accepted in GAP.
- `start` is cleared in every state other than the transition out of IDLE; it is high for exactly one cycle per session.
- Pending arithmetic:
  - The next value of `pend` is `pend` + `req_accepted` − `a_issued`, where `a_issued` is based on the pre-edge `pend`.
  - A simultaneous request and issue leaves `pend` unchanged.
  - When `pend`==`DEPTH` and a request arrives with no issue that cycle, `pend` holds at `DEPTH` and `overflow`<=1. `overflow` clears only on reset.
- A rising edge on `start_in` while `busy`=1 is ignored: no `start` pulse and no session restart.
- A falling edge on `start_in` does not abort the session. All pending requests drain first, then the block returns to IDLE.

## Timing
- Reset values, after any edge with `rst_n`=0: state IDLE, `start`=0, `a`=0, `pend`=0, `busy`=0, `overflow`=0, `start_in_d`=0, `gcnt`=0.
- Reset taken mid-session discards all pending requests immediately.
- Because `start_in_d` resets to 0, a `start_in` held high through reset yields a `start` pulse on the first edge after `rst_n` rises.
- Start latency: if `start_in` rises and is sampled at edge k, then `start` is high for the cycle between edges k and k+1.
- Request latency:
  - A request sampled at edge k (state ACTIVE or GAP) gives `pend`+1 after edge k.
  - The earliest `a` is high after edge k+1.
  - `a` can therefore be high in the cycle immediately after `start`.
- Spacing: after an `a` pulse, `a` stays low for at least `GAP` cycles. The issue rate is therefore at most 1/(`GAP`+1).
- Session teardown: `busy` falls one edge after the cycle in which ACTIVE sees `start_in`=0, `pend`=0 and `req_in`=0.

## Configuration
- `PULSE_SPACER_ASSERT_EN` defined: embeds concurrent SVA clocked on `clk` and disabled while `rst_n` is low. Each property reports pass/fail with `$time`.
  - `$rose(start) |=> not (a[*2])`.
  - `a |=> !a`.
  - `start |=> !start`.
  - `pend <= DEPTH`.
  - `!busy |-> !a`.
- `PULSE_SPACER_ASSERT_EN` undefined: no assertions are compiled. RTL behaviour is identical in both cases.

## Test plan
- Reset then single session, `DEPTH`=4, `GAP`=1:
  - Stimulus: pulse `start_in` 0→1, then one `req_in` at the following edge.
  - Required response: `start` high for 1 cycle; `a` high once, two cycles after the request; `busy` returns to 0 after `start_in` falls.
- Back-to-back requests:
  - Stimulus: `req_in` held high for 3 consecutive cycles in ACTIVE.
  - Required response: `a` follows the pattern 1,0,1,0,1; `pend` peaks at 2; `a` is never high on consecutive cycles.
- Overflow:
  - Stimulus: 6 consecutive requests with `DEPTH`=4, `GAP`=3.
  - Required response: `pend` saturates at 4 and `overflow`=1, sticky until `rst_n`=0.
- Restart while busy:
  - Stimulus: `start_in` toggles 1→0→1 while `pend`>0.
  - Required response: no second `start` pulse; the session drains before IDLE.
- Reset mid-session:
  - Stimulus: assert `rst_n`=0 with `pend`=3 and state GAP.
  - Required response: the next cycle shows all outputs 0 and the state IDLE.
- Requests in IDLE:
  - Stimulus: `req_in`=1 with no session open.
  - Required response: `pend` stays 0 and `a` stays 0.
